// File: rtl/reset_sequencer_if.sv
// Soft-reset request and staged reset status bundle for reset_sequencer.
interface reset_sequencer_if #(
    parameter int unsigned NUM_OUT = 3
);
    logic               req;
    logic [NUM_OUT-1:0] rst_out_n;
    logic               ready;
    logic [1:0]         state;
    logic [7:0]         rst_cnt;

    modport master (output req, input rst_out_n, ready, state, rst_cnt);
    modport slave  (input req, output rst_out_n, ready, state, rst_cnt);
endinterface

// File: rtl/reset_sequencer.sv
// Staged active-low reset generator: immediate assert on power-on or filtered
// soft request, stretched and staggered synchronous release, bit 0 first.
module reset_sequencer #(
    parameter int unsigned STRETCH   = 4,
    parameter int unsigned STAGE_GAP = 2,
    parameter int unsigned NUM_OUT   = 3,
    parameter int unsigned FILTER    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    reset_sequencer_if.slave bus
);

    localparam int unsigned MAX_CNT = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
    localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int unsigned FW      = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned SW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    state_e             state_q;
    logic               s1_q;
    logic               req_s_q;
    logic [FW-1:0]      fcnt_q;
    logic [FW-1:0]      fcnt_d;
    logic [CW-1:0]      cnt_q;
    logic [SW-1:0]      stage_q;
    logic [NUM_OUT-1:0] rst_out_n_q;
    logic               ready_q;
    logic [7:0]         rst_cnt_q;
    logic               req_acc_c;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Request is accepted once req_s has been high for FILTER consecutive edges.
    assign req_acc_c = req_s_q && (fcnt_q == FILT_MAX);

    always_comb begin
        fcnt_d = '0;
        if (req_s_q) begin
            fcnt_d = (fcnt_q == FILT_MAX) ? fcnt_q : fcnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            req_s_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            s1_q    <= bus.req;
            req_s_q <= s1_q;
            fcnt_q  <= fcnt_d;
        end
    end

    // Sequencer FSM; an accepted request outside ASSERT aborts without counting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            stage_q     <= '0;
            rst_out_n_q <= '0;
            ready_q     <= 1'b0;
            rst_cnt_q   <= '0;
        end else if (state_q != ST_ASSERT && req_acc_c) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            stage_q     <= '0;
            rst_out_n_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (!req_s_q) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q       <= '0;
                        stage_q     <= SW'(1);
                        rst_out_n_q <= NUM_OUT'(1);
                        if (NUM_OUT == 1) begin
                            state_q   <= ST_RUN;
                            ready_q   <= 1'b1;
                            rst_cnt_q <= sat_inc(rst_cnt_q);
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q       <= '0;
                        rst_out_n_q <= (rst_out_n_q << 1) | NUM_OUT'(1);
                        if (stage_q == STG_LAST) begin
                            state_q   <= ST_RUN;
                            ready_q   <= 1'b1;
                            rst_cnt_q <= sat_inc(rst_cnt_q);
                        end else begin
                            stage_q <= stage_q + SW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_ASSERT;
            endcase
        end
    end

    assign bus.rst_out_n = rst_out_n_q;
    assign bus.ready     = ready_q;
    assign bus.state     = state_q;
    assign bus.rst_cnt   = rst_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default config plus NUM_OUT=1/STRETCH=1 corner,
// both checked against a release-time reference model every cycle.
module tb_reset_sequencer;

    localparam int unsigned FILTER = 2;
    localparam int unsigned GAP    = 2;

    logic clk = 1'b0;
    logic rst;
    logic req;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_OUT(3)) bus_a ();
    reset_sequencer_if #(.NUM_OUT(1)) bus_b ();

    assign bus_a.req = req;
    assign bus_b.req = req;

    reset_sequencer #(.STRETCH(4), .STAGE_GAP(GAP), .NUM_OUT(3), .FILTER(FILTER)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    reset_sequencer #(.STRETCH(1), .STAGE_GAP(GAP), .NUM_OUT(1), .FILTER(FILTER)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    // Reference model: sync pipe, run length of req_s, and edges since HOLD entry.
    logic        m_s1, m_s, m_acc;
    int unsigned m_hi;
    logic        m_asrt [2];
    int unsigned m_t    [2];
    int unsigned m_cnt  [2];

    function automatic int unsigned cfg_n(input int c);
        return (c == 0) ? 3 : 1;
    endfunction

    function automatic int unsigned n_rel(input int c, input int unsigned t);
        int unsigned s, k;
        s = (c == 0) ? 4 : 1;
        if (t < s) return 0;
        k = 1 + (t - s) / GAP;
        return (k > cfg_n(c)) ? cfg_n(c) : k;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 <= 1'b0;
            m_s  <= 1'b0;
            m_hi <= 0;
            for (int c = 0; c < 2; c++) begin
                m_asrt[c] <= 1'b1;
                m_t[c]    <= 0;
                m_cnt[c]  <= 0;
            end
        end else begin
            m_acc = m_s && (m_hi >= FILTER - 1);
            for (int c = 0; c < 2; c++) begin
                if (m_asrt[c]) begin
                    if (!m_s) begin
                        m_asrt[c] <= 1'b0;
                        m_t[c]    <= 0;
                    end
                end else if (m_acc) begin
                    m_asrt[c] <= 1'b1;
                    m_t[c]    <= 0;
                end else begin
                    m_t[c] <= (m_t[c] < 1000) ? m_t[c] + 1 : m_t[c];
                    if (n_rel(c, m_t[c] + 1) == cfg_n(c) && n_rel(c, m_t[c]) < cfg_n(c)
                        && m_cnt[c] < 255)
                        m_cnt[c] <= m_cnt[c] + 1;
                end
            end
            m_hi <= m_s ? ((m_hi < 100) ? m_hi + 1 : m_hi) : 0;
            m_s  <= m_s1;
            m_s1 <= req;
        end
    end

    function automatic logic [13:0] mexp(input int c);
        int unsigned n;
        logic [2:0]  th;
        logic [1:0]  st;
        logic        rdy;
        n   = m_asrt[c] ? 0 : n_rel(c, m_t[c]);
        th  = 3'((1 << n) - 1);
        rdy = !m_asrt[c] && (n == cfg_n(c));
        st  = m_asrt[c] ? 2'd0 : (n == 0) ? 2'd1 : (n < cfg_n(c)) ? 2'd2 : 2'd3;
        if (c == 0) return {th, rdy, st, 8'(m_cnt[c])};
        return {2'b00, th[0], rdy, st, 8'(m_cnt[c])};
    endfunction

    function automatic logic [13:0] pack_a();
        return {bus_a.rst_out_n, bus_a.ready, bus_a.state, bus_a.rst_cnt};
    endfunction

    function automatic logic [13:0] pack_b();
        return {2'b00, bus_b.rst_out_n, bus_b.ready, bus_b.state, bus_b.rst_cnt};
    endfunction

    function automatic logic [13:0] pa(input logic [2:0] o, input logic r,
                                       input logic [1:0] s, input logic [7:0] c);
        return {o, r, s, c};
    endfunction

    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got out/rdy/st/cnt=%h expected %h at %0t", name, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("model_a", pack_a(), mexp(0));
        chk("model_b", pack_b(), mexp(1));
    endtask

    typedef struct {
        logic        rst;
        logic        req;
        logic [13:0] exp_a;
        logic [1:0]  exp_b;
    } vec_t;

    vec_t tbl [13];

    initial begin
        rst = 1'b1;
        req = 1'b0;

        // Power-on: 3 reset cycles, then edges 0..9.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, pa(3'b000, 1'b0, 2'd0, 8'd0), 2'b00};
        tbl[3]  = '{1'b0, 1'b0, pa(3'b000, 1'b0, 2'd1, 8'd0), 2'b00};
        for (int i = 4; i < 7; i++) tbl[i] = '{1'b0, 1'b0, pa(3'b000, 1'b0, 2'd1, 8'd0), 2'b11};
        tbl[7]  = '{1'b0, 1'b0, pa(3'b001, 1'b0, 2'd2, 8'd0), 2'b11};
        tbl[8]  = '{1'b0, 1'b0, pa(3'b001, 1'b0, 2'd2, 8'd0), 2'b11};
        tbl[9]  = '{1'b0, 1'b0, pa(3'b011, 1'b0, 2'd2, 8'd0), 2'b11};
        tbl[10] = '{1'b0, 1'b0, pa(3'b011, 1'b0, 2'd2, 8'd0), 2'b11};
        tbl[11] = '{1'b0, 1'b0, pa(3'b111, 1'b1, 2'd3, 8'd1), 2'b11};
        tbl[12] = '{1'b0, 1'b0, pa(3'b111, 1'b1, 2'd3, 8'd1), 2'b11};

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            tick();
            chk($sformatf("poweron_a[%0d]", i), pack_a(), tbl[i].exp_a);
            chk($sformatf("poweron_b[%0d]", i), 14'({bus_b.rst_out_n, bus_b.ready}),
                14'(tbl[i].exp_b));
        end

        // Soft reset from RUN: 5-cycle request.
        req = 1'b1;
        repeat (3) tick();
        chk("soft_before_drop", pack_a(), pa(3'b111, 1'b1, 2'd3, 8'd1));
        tick();
        chk("soft_drop", pack_a(), pa(3'b000, 1'b0, 2'd0, 8'd1));
        tick();
        req = 1'b0;
        repeat (2) tick();
        chk("soft_still_assert", pack_a(), pa(3'b000, 1'b0, 2'd0, 8'd1));
        tick();
        chk("soft_hold", pack_a(), pa(3'b000, 1'b0, 2'd1, 8'd1));
        repeat (3) tick();
        tick();
        chk("soft_bit0", pack_a(), pa(3'b001, 1'b0, 2'd2, 8'd1));
        repeat (3) tick();
        tick();
        chk("soft_done", pack_a(), pa(3'b111, 1'b1, 2'd3, 8'd2));

        // One-cycle glitch must be ignored.
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (6) begin
            tick();
            chk("glitch", pack_a(), pa(3'b111, 1'b1, 2'd3, 8'd2));
        end

        // Abort right after bit 0 releases (relative edge 5).
        req = 1'b1;
        repeat (4) tick();
        chk("abort_enter_assert", pack_a(), pa(3'b000, 1'b0, 2'd0, 8'd2));
        req = 1'b0;
        repeat (4) tick();
        chk("abort_hold", pack_a(), pa(3'b000, 1'b0, 2'd1, 8'd2));
        req = 1'b1;
        repeat (3) tick();
        chk("abort_bit0", pack_a(), pa(3'b001, 1'b0, 2'd2, 8'd2));
        tick();
        chk("abort_drop", pack_a(), pa(3'b000, 1'b0, 2'd0, 8'd2));
        req = 1'b0;
        repeat (14) tick();
        chk("abort_recover", pack_a(), pa(3'b111, 1'b1, 2'd3, 8'd3));

        // Async reset pulse between edges during RELEASE.
        req = 1'b1;
        repeat (4) tick();
        req = 1'b0;
        repeat (7) tick();
        chk("async_pre", pack_a(), pa(3'b001, 1'b0, 2'd2, 8'd3));
        #2 rst = 1'b1;
        #1;
        chk("async_now_a", pack_a(), pa(3'b000, 1'b0, 2'd0, 8'd0));
        chk("async_now_b", pack_b(), 14'd0);
        #1 rst = 1'b0;
        repeat (9) tick();
        chk("async_recover", pack_a(), pa(3'b111, 1'b1, 2'd3, 8'd1));

        // Counter saturation.
        repeat (260) begin
            req = 1'b1;
            repeat (4) tick();
            req = 1'b0;
            repeat (12) tick();
        end
        chk("sat_a", pack_a(), pa(3'b111, 1'b1, 2'd3, 8'd255));
        chk("sat_b", pack_b(), {2'b00, 1'b1, 1'b1, 2'd3, 8'd255});

        // Random request lengths with occasional async reset pulses.
        repeat (400) begin
            req = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) tick();
            if ($urandom_range(0, 19) == 0) begin
                #2 rst = 1'b1;
                #1;
                chk("rand_async_a", pack_a(), mexp(0));
                chk("rand_async_b", pack_b(), mexp(1));
                #1 rst = 1'b0;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
